// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver: hex decode, anti-ghost blanking,
// leading-zero suppression, decimal points and frame-latched display data.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          HEX_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PresMax = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BlankEnd = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IdxMax = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic       tick;
  logic [3:0] nib;
  logic       nib_dp;
  logic       zero_run;
  logic       lz_hit;
  logic       lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0001100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (!HEX_EN && (n > 4'd9)) s = 7'b1111111;
    return s;
  endfunction

  // Scan timing and frame latch
  always_comb begin
    tick          = (prescaler_q == PresMax);
    prescaler_d   = tick ? '0 : prescaler_q + PW'(1);
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    shadow_dp_d   = shadow_dp_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (idx_q == IdxMax) begin
        idx_d         = '0;
        shadow_d      = value;
        shadow_dp_d   = dp_in;
        frame_start_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Digit selection; zero_run tracks "every nibble from the top down to i is zero"
  always_comb begin
    nib      = 4'h0;
    nib_dp   = 1'b0;
    zero_run = 1'b1;
    lz_hit   = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib    = shadow_q[4*i +: 4];
        nib_dp = shadow_dp_q[i];
        lz_hit = zero_run && (i != 0);
      end
    end
  end

  always_comb begin
    lit   = enable && (prescaler_q >= BlankEnd);
    seg_d = (lz_blank && lz_hit) ? 7'b1111111 : seg_decode(nib);
    dp_d  = lit ? ~nib_dp : 1'b1;
    an_d  = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      an_d[i] = ~(lit && (idx_q == IW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      shadow_dp_q   <= '0;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (hex on/off) checked every cycle against a
// cycle-count based display model, plus literal checks at hand-computed points.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_blank = 1'b0;
  logic        enable = 1'b1;

  logic [6:0] seg_h, seg_n;
  logic       dp_h, dp_n;
  logic [3:0] an_h, an_n;
  logic       fs_h, fs_n;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_EN(1'b1)
  ) dut_h (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .enable(enable), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_start(fs_h)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_EN(1'b0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .enable(enable), .seg(seg_n), .dp(dp_n), .an(an_n), .frame_start(fs_n)
  );

  // Glyph table, active low {a..g}
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,
    7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010,
    7'b0110000, 7'b0111000
  };

  // Model: k = clock edges since reset; the outputs after edge k show the scan position
  // of count k (slot = k/4, phase = k%4), using the frame data latched at the last wrap.
  int          k = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [3:0]  m_shadow_dp = 4'h0;
  logic [6:0]  exp_seg_h = 7'h7f, exp_seg_n = 7'h7f;
  logic        exp_dp = 1'b1;
  logic [3:0]  exp_an = 4'hf;
  logic        exp_fs = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int p, d, nib;
    bit lit, supp;
    if (!rst_n) begin
      k = 0;
      m_shadow = 16'h0;
      m_shadow_dp = 4'h0;
      exp_seg_h = 7'h7f;
      exp_seg_n = 7'h7f;
      exp_dp = 1'b1;
      exp_an = 4'hf;
      exp_fs = 1'b0;
    end else begin
      p = k % 4;
      d = (k / 4) % 4;
      nib = int'((m_shadow >> (4 * d)) & 16'hf);
      supp = lz_blank && (d > 0) && ((m_shadow >> (4 * d)) == 16'h0);
      lit = enable && (p >= 1);
      exp_seg_h = supp ? 7'h7f : glyph[nib];
      exp_seg_n = (supp || nib > 9) ? 7'h7f : glyph[nib];
      exp_an = lit ? ~(4'b0001 << d) : 4'hf;
      exp_dp = lit ? ~m_shadow_dp[d] : 1'b1;
      exp_fs = ((k % 16) == 15);
      if ((k % 16) == 15) begin
        m_shadow = value;
        m_shadow_dp = dp_in;
      end
      k++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("seg_hex", 32'(seg_h), 32'(exp_seg_h));
      check("seg_nohex", 32'(seg_n), 32'(exp_seg_n));
      check("an_hex", 32'(an_h), 32'(exp_an));
      check("an_nohex", 32'(an_n), 32'(exp_an));
      check("dp_hex", 32'(dp_h), 32'(exp_dp));
      check("dp_nohex", 32'(dp_n), 32'(exp_dp));
      check("fs_hex", 32'(fs_h), 32'(exp_fs));
      check("fs_nohex", 32'(fs_n), 32'(exp_fs));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait until the model says the given anode pattern is showing
  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (exp_an !== target && n < 64) begin
      step(1);
      n++;
    end
    check("wait_an_timeout", 32'(exp_an), 32'(target));
  endtask

  task automatic randomize_inputs();
    value    = 16'($urandom);
    dp_in    = 4'($urandom);
    lz_blank = 1'($urandom);
    enable   = ($urandom_range(0, 5) != 0);
    if ($urandom_range(0, 3) == 0) value = value & 16'h00ff;
  endtask

  initial begin
    value = 16'h1234;
    dp_in = 4'h0;
    lz_blank = 1'b0;
    enable = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an_h), 32'h0000000f);
    check("rst_seg", 32'(seg_h), 32'h0000007f);
    check("rst_dp", 32'(dp_h), 32'h00000001);
    check("rst_fs", 32'(fs_h), 32'h00000000);
    step(2);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // First frame shows shadow=0; second frame shows 1234
    step(1);
    check("f0_blank_an", 32'(an_h), 32'h0000000e | 32'h1);
    check("f0_blank_seg", 32'(seg_h), 32'b0000001);
    step(1);
    check("f0_d0_an", 32'(an_h), 32'b1110);
    check("f0_d0_seg", 32'(seg_h), 32'b0000001);
    check("model_f0_an", 32'(exp_an), 32'b1110);
    step(14);
    check("frame_start", 32'(fs_h), 32'h1);
    check("model_fs", 32'(exp_fs), 32'h1);
    step(2);
    check("f1_d0_an", 32'(an_h), 32'b1110);
    check("f1_d0_seg", 32'(seg_h), 32'b1001100);
    check("model_f1_d0", 32'(exp_seg_h), 32'b1001100);
    step(12);
    check("f1_d3_an", 32'(an_h), 32'b0111);
    check("f1_d3_seg", 32'(seg_h), 32'b1001111);

    // Leading-zero suppression
    value = 16'h0050;
    lz_blank = 1'b1;
    step(40);
    value = 16'h0000;
    step(36);
    check("model_lz_d0", 32'(glyph[0]), 32'b0000001);

    // Hex letters vs blanked on the no-hex instance
    lz_blank = 1'b0;
    value = 16'hABCD;
    step(40);

    // Mid-frame change must not show until the next wrap
    value = 16'h1111;
    step(20);
    wait_an(4'b1011);
    value = 16'h2222;
    step(1);
    check("hold_d2_seg", 32'(seg_h), 32'b1001111);
    step(40);

    // Decimal point with enable dropped for six cycles
    dp_in = 4'b0100;
    step(10);
    enable = 1'b0;
    step(6);
    enable = 1'b1;
    step(24);

    repeat (400) begin
      if ($urandom_range(0, 6) == 0) randomize_inputs();
      step(1);
    end

    // Asynchronous reset mid-slot on digit 2
    value = 16'h9999;
    enable = 1'b1;
    lz_blank = 1'b0;
    step(20);
    wait_an(4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an_h), 32'hf);
    check("arst_seg", 32'(seg_h), 32'h7f);
    check("arst_fs", 32'(fs_h), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_rst_an", 32'(an_h), 32'b1110);
    check("post_rst_seg", 32'(seg_h), 32'b0000001);

    repeat (200) begin
      if ($urandom_range(0, 6) == 0) randomize_inputs();
      step(1);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
